// File: rtl/timer_mc_core_if.sv
// Bus between the timer software-register block (master) and the multi-channel timer core (slave).
// Channel k of each flattened bus occupies slice [k*W +: W].
interface timer_mc_core_if #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
);
  logic                    cke_i;
  logic [PRESC_W-1:0]      presc_div_i;
  logic [N_CH-1:0]         ch_en_i;
  logic [2*N_CH-1:0]       ch_mode_i;
  logic [N_CH-1:0]         ch_start_i;
  logic [N_CH*CNT_W-1:0]   ch_cmp_i;
  logic [N_CH-1:0]         ch_sample_i;
  logic [N_CH-1:0]         ch_irq_clr_i;
  logic [N_CH*CNT_W-1:0]   ch_count_o;
  logic [N_CH*CNT_W-1:0]   ch_value_o;
  logic [N_CH-1:0]         ch_match_o;
  logic [N_CH-1:0]         ch_irq_o;
  logic [N_CH-1:0]         ch_running_o;

  modport master (
    output cke_i, presc_div_i, ch_en_i, ch_mode_i, ch_start_i,
           ch_cmp_i, ch_sample_i, ch_irq_clr_i,
    input  ch_count_o, ch_value_o, ch_match_o, ch_irq_o, ch_running_o
  );

  modport slave (
    input  cke_i, presc_div_i, ch_en_i, ch_mode_i, ch_start_i,
           ch_cmp_i, ch_sample_i, ch_irq_clr_i,
    output ch_count_o, ch_value_o, ch_match_o, ch_irq_o, ch_running_o
  );
endinterface

// File: rtl/timer_mc_core.sv
// Multi-channel timer: shared prescaler ticking N_CH counters with compare, free-run/periodic/one-shot,
// registered match pulse, sticky irq and snapshot. All outputs registered; cke_i low freezes every register.
module timer_mc_core #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  timer_mc_core_if.slave bus
);

  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  logic [PRESC_W-1:0]          pc_q, pc_d;
  logic                        tick;

  logic [N_CH-1:0][CNT_W-1:0]  count_q, count_d;
  logic [N_CH-1:0][CNT_W-1:0]  value_q, value_d;
  logic [N_CH-1:0]             running_q, running_d;
  logic [N_CH-1:0]             irq_q, irq_d;
  logic [N_CH-1:0]             match_q, match_d;

  logic [N_CH-1:0][CNT_W-1:0]  cmp_w;
  logic [N_CH-1:0][1:0]        mode_w;
  logic [N_CH-1:0]             cnt_en;
  logic [N_CH-1:0]             hit;

  assign cmp_w  = bus.ch_cmp_i;
  assign mode_w = bus.ch_mode_i;

  // Lowering presc_div_i below pc_q simply lets pc wrap through 2^PRESC_W.
  always_comb begin
    tick = (pc_q == bus.presc_div_i);
    pc_d = tick ? '0 : pc_q + PRESC_W'(1);
  end

  always_comb begin
    count_d   = count_q;
    value_d   = value_q;
    running_d = running_q;
    irq_d     = irq_q;
    match_d   = '0;
    cnt_en    = '0;
    hit       = '0;

    for (int k = 0; k < N_CH; k++) begin
      cnt_en[k] = tick & bus.ch_en_i[k] & running_q[k];
      hit[k]    = cnt_en[k] & (count_q[k] == cmp_w[k]);

      // Start wins over any counting update; a one-shot hit parks the count at cmp.
      if (bus.ch_start_i[k]) begin
        count_d[k] = '0;
      end else if (hit[k] && (mode_w[k] == MODE_PERIODIC)) begin
        count_d[k] = '0;
      end else if (cnt_en[k] && !(hit[k] && (mode_w[k] == MODE_ONESHOT))) begin
        count_d[k] = count_q[k] + CNT_W'(1);
      end

      if (bus.ch_start_i[k] || (mode_w[k] != MODE_ONESHOT)) begin
        running_d[k] = 1'b1;
      end else if (hit[k]) begin
        running_d[k] = 1'b0;
      end

      // Snapshot takes the registered count, never the value being written this cycle.
      if (bus.ch_sample_i[k]) begin
        value_d[k] = count_q[k];
      end

      irq_d[k]   = hit[k] | (irq_q[k] & ~bus.ch_irq_clr_i[k]);
      match_d[k] = hit[k];
    end

    if (!bus.cke_i) begin
      count_d   = count_q;
      value_d   = value_q;
      running_d = running_q;
      irq_d     = irq_q;
      match_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= '0;
      count_q   <= '0;
      value_q   <= '0;
      running_q <= '1;
      irq_q     <= '0;
      match_q   <= '0;
    end else begin
      if (bus.cke_i) begin
        pc_q <= pc_d;
      end
      count_q   <= count_d;
      value_q   <= value_d;
      running_q <= running_d;
      irq_q     <= irq_d;
      match_q   <= match_d;
    end
  end

  assign bus.ch_count_o   = count_q;
  assign bus.ch_value_o   = value_q;
  assign bus.ch_running_o = running_q;
  assign bus.ch_irq_o     = irq_q;
  assign bus.ch_match_o   = match_q;

endmodule

// File: tb/tb_timer_mc_core.sv
// Directed bench for timer_mc_core with CNT_W=8; expected values are hand-derived per cycle.
module tb_timer_mc_core;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  timer_mc_core_if #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) bus ();

  timer_mc_core #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int mcnt [N_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges; outputs are observed 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N_CH; k++) mcnt[k] += int'(bus.ch_match_o[k]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int k = 0; k < N_CH; k++) mcnt[k] = 0;
  endtask

  function automatic logic [CNT_W-1:0] cnt(input int k);
    return bus.ch_count_o[k*CNT_W +: CNT_W];
  endfunction

  function automatic logic [CNT_W-1:0] val(input int k);
    return bus.ch_value_o[k*CNT_W +: CNT_W];
  endfunction

  initial begin
    bus.cke_i        = 1'b1;
    bus.presc_div_i  = '0;
    bus.ch_en_i      = 4'b0001;
    bus.ch_mode_i    = '0;
    bus.ch_start_i   = '0;
    bus.ch_cmp_i     = {N_CH*CNT_W{1'b1}};
    bus.ch_sample_i  = '0;
    bus.ch_irq_clr_i = '0;

    // Reset state and free-run wrap on ch0, D=0, cmp=0xFF
    do_reset();
    chk("rst_count",   bus.ch_count_o, '0);
    chk("rst_value",   bus.ch_value_o, '0);
    chk("rst_match",   bus.ch_match_o, '0);
    chk("rst_irq",     bus.ch_irq_o, '0);
    chk("rst_running", bus.ch_running_o, 4'hF);
    step(1);
    chk("fr_first_tick", cnt(0), 8'd1);
    step(8);
    chk("fr_cnt9", cnt(0), 8'd9);
    bus.ch_sample_i = 4'b0001;
    step(1);
    bus.ch_sample_i = '0;
    chk("smp_count", cnt(0), 8'd10);
    chk("smp_value", val(0), 8'd9);
    step(245);
    chk("fr_cnt_ff", cnt(0), 8'hFF);
    chk("fr_nomatch_ff", bus.ch_match_o[0], 1'b0);
    chk("fr_noirq_ff", bus.ch_irq_o[0], 1'b0);
    bus.ch_irq_clr_i = 4'b0001;
    step(1);
    bus.ch_irq_clr_i = '0;
    chk("fr_wrap_cnt", cnt(0), 8'd0);
    chk("fr_wrap_match", bus.ch_match_o[0], 1'b1);
    chk("irq_set_beats_clr", bus.ch_irq_o[0], 1'b1);
    step(1);
    chk("fr_match_1cyc", bus.ch_match_o[0], 1'b0);
    step(10);
    chk("fr_cnt11", cnt(0), 8'd11);
    chk("fr_irq_sticky", bus.ch_irq_o[0], 1'b1);
    chk("fr_match_total", mcnt[0], 1);
    bus.ch_irq_clr_i = 4'b0001;
    step(1);
    bus.ch_irq_clr_i = '0;
    chk("irq_clr", bus.ch_irq_o[0], 1'b0);
    chk("fr_cnt12", cnt(0), 8'd12);
    bus.ch_start_i = 4'b0001;
    step(1);
    bus.ch_start_i = '0;
    chk("start_vs_tick", cnt(0), 8'd0);
    chk("ch1_idle", cnt(1), 8'd0);
    step(1);
    chk("after_start", cnt(0), 8'd1);

    // Periodic ch1, D=3, cmp=4 -> period 20, then cmp=1 -> period 8
    bus.presc_div_i = 16'd3;
    bus.ch_en_i     = 4'b0010;
    bus.ch_mode_i   = 8'b0000_0100;
    bus.ch_cmp_i[1*CNT_W +: CNT_W] = 8'd4;
    do_reset();
    step(3);
    chk("per_hold0", cnt(1), 8'd0);
    step(1);
    chk("per_tick1", cnt(1), 8'd1);
    step(3);
    chk("per_hold1", cnt(1), 8'd1);
    step(1);
    chk("per_tick2", cnt(1), 8'd2);
    step(11);
    chk("per_cnt4", cnt(1), 8'd4);
    chk("per_nomatch", bus.ch_match_o[1], 1'b0);
    step(1);
    chk("per_wrap_cnt", cnt(1), 8'd0);
    chk("per_match20", bus.ch_match_o[1], 1'b1);
    chk("per_irq", bus.ch_irq_o[1], 1'b1);
    step(19);
    chk("per_cnt4_b", cnt(1), 8'd4);
    step(1);
    chk("per_match40", bus.ch_match_o[1], 1'b1);
    chk("per_matches_2", mcnt[1], 2);
    bus.ch_cmp_i[1*CNT_W +: CNT_W] = 8'd1;
    step(4);
    chk("per_c1_tick", cnt(1), 8'd1);
    step(4);
    chk("per_c1_wrap", cnt(1), 8'd0);
    chk("per_match48", bus.ch_match_o[1], 1'b1);
    step(8);
    chk("per_match56", bus.ch_match_o[1], 1'b1);
    step(4);
    chk("per_c1_cnt", cnt(1), 8'd1);
    chk("per_matches_4", mcnt[1], 4);

    // One-shot ch2, D=0, cmp=5
    bus.presc_div_i = 16'd0;
    bus.ch_en_i     = 4'b0100;
    bus.ch_mode_i   = 8'b0010_0000;
    bus.ch_cmp_i[2*CNT_W +: CNT_W] = 8'd5;
    do_reset();
    step(5);
    chk("os_cnt5", cnt(2), 8'd5);
    chk("os_run_pre", bus.ch_running_o[2], 1'b1);
    step(1);
    chk("os_match", bus.ch_match_o[2], 1'b1);
    chk("os_hold", cnt(2), 8'd5);
    chk("os_stopped", bus.ch_running_o[2], 1'b0);
    step(3);
    chk("os_hold_b", cnt(2), 8'd5);
    bus.ch_start_i = 4'b0100;
    step(1);
    bus.ch_start_i = '0;
    chk("os_start_cnt", cnt(2), 8'd0);
    chk("os_start_run", bus.ch_running_o[2], 1'b1);
    step(5);
    chk("os_no_early", bus.ch_match_o[2], 1'b0);
    step(1);
    chk("os_match2", bus.ch_match_o[2], 1'b1);
    chk("os_stopped2", bus.ch_running_o[2], 1'b0);
    bus.ch_start_i = 4'b0100;
    step(1);
    bus.ch_start_i = '0;
    step(6);
    chk("os_match3", bus.ch_match_o[2], 1'b1);
    chk("os_matches_3", mcnt[2], 3);

    // Enable and cke gating, D=2, ch0/ch1 free-run
    bus.presc_div_i = 16'd2;
    bus.ch_en_i     = 4'b0011;
    bus.ch_mode_i   = '0;
    do_reset();
    step(4);
    chk("gate_c0_a", cnt(0), 8'd1);
    chk("gate_c1_a", cnt(1), 8'd1);
    bus.ch_en_i = 4'b0010;
    step(10);
    bus.ch_en_i = 4'b0011;
    chk("en_c0_frozen", cnt(0), 8'd1);
    chk("en_c1_runs", cnt(1), 8'd4);
    step(1);
    chk("en_c0_resume", cnt(0), 8'd2);
    chk("en_c1_b", cnt(1), 8'd5);
    bus.cke_i = 1'b0;
    step(10);
    bus.cke_i = 1'b1;
    chk("cke_c0_frozen", cnt(0), 8'd2);
    chk("cke_c1_frozen", cnt(1), 8'd5);
    step(2);
    chk("cke_phase_c1", cnt(1), 8'd5);
    step(1);
    chk("cke_tick_c0", cnt(0), 8'd3);
    chk("cke_tick_c1", cnt(1), 8'd6);

    // Reset mid-operation with count=7, irq=1, value=3, running=0 on ch2
    bus.presc_div_i = 16'd0;
    bus.ch_en_i     = 4'b0100;
    bus.ch_mode_i   = 8'b0010_0000;
    bus.ch_cmp_i[2*CNT_W +: CNT_W] = 8'd7;
    do_reset();
    step(3);
    bus.ch_sample_i = 4'b0100;
    step(1);
    bus.ch_sample_i = '0;
    chk("mr_value3", val(2), 8'd3);
    step(4);
    chk("mr_cnt7", cnt(2), 8'd7);
    chk("mr_irq", bus.ch_irq_o[2], 1'b1);
    chk("mr_stopped", bus.ch_running_o[2], 1'b0);
    rst = 1'b1;
    bus.cke_i = 1'b0;
    step(1);
    rst = 1'b0;
    bus.cke_i = 1'b1;
    chk("mr_count", bus.ch_count_o, '0);
    chk("mr_value", bus.ch_value_o, '0);
    chk("mr_match", bus.ch_match_o, '0);
    chk("mr_irq_clr", bus.ch_irq_o, '0);
    chk("mr_running", bus.ch_running_o, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
